// File: rtl/dt_pkg.sv
// Constants shared by the distance-transform engine and its image loader.
// Also holds the loader's state encoding.
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int WORD_BITS = 16;
  localparam int ROM_WORDS = 1024;
  localparam int RAM_BYTES = 16384;

  typedef logic [2:0] ld_state_t;

  localparam ld_state_t ST_IDLE    = 3'd0;
  localparam ld_state_t ST_FETCH   = 3'd1;
  localparam ld_state_t ST_CAPTURE = 3'd2;
  localparam ld_state_t ST_WRITE   = 3'd3;
  localparam ld_state_t ST_FINISH  = 3'd4;

endpackage

// File: rtl/dt_obj_stats.sv
// Object-pixel statistics: count of 1-pixels plus the first and last occupied row.
// Cleared at the start of every load; the values are held between loads.
module dt_obj_stats
  import dt_pkg::*;
#(
  parameter int ROW_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_pix,
  input  logic [ROW_W-1:0] i_row,
  output logic [2*ROW_W:0] o_obj_cnt,
  output logic [ROW_W-1:0] o_row_min,
  output logic [ROW_W-1:0] o_row_max
);

  logic [2*ROW_W:0] r_obj_cnt;
  logic [ROW_W-1:0] r_row_min;
  logic [ROW_W-1:0] r_row_max;

  // row_min starts at the last row so that the first hit always replaces it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_obj_cnt <= '0;
      r_row_min <= '1;
      r_row_max <= '0;
    end else if (i_clear) begin
      r_obj_cnt <= '0;
      r_row_min <= '1;
      r_row_max <= '0;
    end else if (i_valid && i_pix) begin
      r_obj_cnt <= r_obj_cnt + 1'b1;
      if (i_row < r_row_min) r_row_min <= i_row;
      if (i_row > r_row_max) r_row_max <= i_row;
    end
  end

  assign o_obj_cnt = r_obj_cnt;
  assign o_row_min = r_row_min;
  assign o_row_max = r_row_max;

endmodule

// File: rtl/dt_img_loader.sv
// Expands the packed binary source image from the stimulus ROM into one byte
// per pixel in the result RAM, gathering object statistics on the way.
module dt_img_loader
  import dt_pkg::*;
#(
  parameter int IMG_W     = dt_pkg::IMG_W,
  parameter int WORD_BITS = dt_pkg::WORD_BITS,
  localparam int ROW_W    = $clog2(IMG_W),
  localparam int BIT_W    = $clog2(WORD_BITS),
  localparam int ADDR_W   = 2 * ROW_W,
  localparam int WIDX_W   = ADDR_W - BIT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 load_done,
  output logic                 sti_rd,
  output logic [WIDX_W-1:0]    sti_addr,
  input  logic [WORD_BITS-1:0] sti_di,
  output logic                 res_wr,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [7:0]           res_do,
  output logic [ADDR_W:0]      obj_cnt,
  output logic [ROW_W-1:0]     row_min,
  output logic [ROW_W-1:0]     row_max,
  output logic                 rows_valid
);

  ld_state_t            r_state;
  logic [WIDX_W-1:0]    r_word_idx;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] r_next;
  logic                 r_rows_valid;

  logic w_writing;
  logic w_last_word;
  logic w_prefetch;
  logic w_clear;

  assign w_writing   = (r_state == ST_WRITE);
  assign w_last_word = (r_word_idx == '1);
  assign w_clear     = (r_state == ST_IDLE) && start;
  // Next word is requested three pixels early so it is ready with no write bubble
  assign w_prefetch  = w_writing && (r_bit_cnt == BIT_W'(WORD_BITS - 3)) && !w_last_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_word_idx   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_next       <= '0;
      r_rows_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_FETCH;
            r_rows_valid <= 1'b0;
            r_word_idx   <= '0;
            r_bit_cnt    <= '0;
          end
        end
        ST_FETCH: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_shift    <= sti_di;
          r_word_idx <= '0;
          r_bit_cnt  <= '0;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= r_shift << 1;
          if (r_bit_cnt == BIT_W'(WORD_BITS - 2)) r_next <= sti_di;
          if (r_bit_cnt == BIT_W'(WORD_BITS - 1)) begin
            r_shift    <= r_next;
            r_word_idx <= r_word_idx + 1'b1;
            if (w_last_word) r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_rows_valid <= (obj_cnt != '0);
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_FETCH) || (r_state == ST_CAPTURE) || w_writing;
  assign load_done = (r_state == ST_FINISH);
  assign sti_rd    = (r_state == ST_FETCH) || w_prefetch;
  assign sti_addr  = w_prefetch ? (r_word_idx + 1'b1) : '0;
  assign res_wr    = w_writing;
  assign res_addr  = w_writing ? {r_word_idx, r_bit_cnt} : '0;
  assign res_do    = {7'b0, w_writing & r_shift[WORD_BITS-1]};
  assign rows_valid = r_rows_valid;

  dt_obj_stats #(.ROW_W(ROW_W)) u_stats (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_valid  (w_writing),
    .i_pix    (r_shift[WORD_BITS-1]),
    .i_row    (r_word_idx[WIDX_W-1 -: ROW_W]),
    .o_obj_cnt(obj_cnt),
    .o_row_min(row_min),
    .o_row_max(row_max)
  );

endmodule

// File: tb/tb_dt_img_loader.sv
// Directed self-checking bench for dt_img_loader with a behavioural ROM and RAM.
// Each load is checked for latency, write order, ROM reads, image content and statistics.
module tb_dt_img_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        load_done;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic [14:0] obj_cnt;
  logic [6:0]  row_min;
  logic [6:0]  row_max;
  logic        rows_valid;

  logic [15:0] rom [1024];
  logic [7:0]  ram [16384];
  logic [15:0] romQ = 16'h0;

  int cyc = 0;
  int startCyc = 0, firstWr = -1, lastWr = -1;
  int wrCnt = 0, wrBad = 0, rdCnt = 0, rdBad = 0, doneCnt = 0;
  int checks = 0, passes = 0, fails = 0;

  dt_img_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .load_done (load_done),
    .sti_rd    (sti_rd),
    .sti_addr  (sti_addr),
    .sti_di    (sti_di),
    .res_wr    (res_wr),
    .res_addr  (res_addr),
    .res_do    (res_do),
    .obj_cnt   (obj_cnt),
    .row_min   (row_min),
    .row_max   (row_max),
    .rows_valid(rows_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM answers one cycle after the read strobe
  always @(posedge clk) if (sti_rd) romQ <= rom[sti_addr];
  assign sti_di = romQ;

  always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

  // Bus monitor, restarted whenever an accepted start is seen
  always @(posedge clk) begin
    if (start && !busy && !load_done && !reset) begin
      startCyc <= cyc; firstWr <= -1; lastWr <= -1;
      wrCnt <= 0; wrBad <= 0; rdCnt <= 0; rdBad <= 0; doneCnt <= 0;
    end else begin
      if (res_wr) begin
        if (res_addr != wrCnt[13:0] || wrCnt >= 16384) wrBad <= wrBad + 1;
        wrCnt <= wrCnt + 1;
        if (firstWr < 0) firstWr <= cyc;
        lastWr <= cyc;
      end
      if (sti_rd) begin
        if (sti_addr != rdCnt[9:0] || rdCnt >= 1024) rdBad <= rdBad + 1;
        rdCnt <= rdCnt + 1;
      end
      if (load_done) doneCnt <= doneCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Pulse start and run until load_done; optional second start and clear check
  task automatic applyStimulus(input int extraStartAt, input bit chkClr, output int lat);
    int n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 1;
    lat = -1;
    while (n < 20000 && lat < 0) begin
      if (chkClr && n == 1) begin
        checkOutput("clr_obj_cnt", int'(obj_cnt), 0);
        checkOutput("clr_row_min", int'(row_min), 127);
        checkOutput("clr_rows_valid", int'(rows_valid), 0);
        checkOutput("clr_busy", int'(busy), 1);
      end
      if (load_done) lat = n;
      else begin
        start = (n == extraStartAt);
        tick(1);
        n++;
      end
    end
    start = 1'b0;
    tick(20);
  endtask

  task automatic verifyRun(input string nm, input int lat, input int eObj, input int eMin,
                           input int eMax, input int eValid);
    int bad, ones;
    bad = 0;
    ones = 0;
    for (int a = 0; a < 16384; a++) begin
      logic [15:0] w;
      w = rom[a >> 4];
      if (ram[a] !== {7'b0, w[15 - (a & 15)]}) bad++;
      if (ram[a] == 8'd1) ones++;
    end
    checkOutput({nm, "_latency"}, lat, 16387);
    checkOutput({nm, "_wr_count"}, wrCnt, 16384);
    checkOutput({nm, "_wr_order"}, wrBad, 0);
    checkOutput({nm, "_wr_span"}, lastWr - firstWr + 1, 16384);
    checkOutput({nm, "_first_wr"}, firstWr - startCyc, 3);
    checkOutput({nm, "_rd_count"}, rdCnt, 1024);
    checkOutput({nm, "_rd_order"}, rdBad, 0);
    checkOutput({nm, "_done_pulses"}, doneCnt, 1);
    checkOutput({nm, "_image"}, bad, 0);
    checkOutput({nm, "_ones"}, ones, eObj);
    checkOutput({nm, "_obj_cnt"}, int'(obj_cnt), eObj);
    checkOutput({nm, "_row_min"}, int'(row_min), eMin);
    checkOutput({nm, "_row_max"}, int'(row_max), eMax);
    checkOutput({nm, "_rows_valid"}, int'(rows_valid), eValid);
    checkOutput({nm, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    int snap;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    tick(3);

    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_load_done", int'(load_done), 0);
    checkOutput("rst_sti_rd", int'(sti_rd), 0);
    checkOutput("rst_sti_addr", int'(sti_addr), 0);
    checkOutput("rst_res_wr", int'(res_wr), 0);
    checkOutput("rst_res_addr", int'(res_addr), 0);
    checkOutput("rst_res_do", int'(res_do), 0);
    checkOutput("rst_obj_cnt", int'(obj_cnt), 0);
    checkOutput("rst_row_min", int'(row_min), 127);
    checkOutput("rst_row_max", int'(row_max), 0);
    checkOutput("rst_rows_valid", int'(rows_valid), 0);
    reset = 1'b0;
    tick(2);

    $display("[TB] run: all-zero image");
    applyStimulus(0, 1'b0, lat);
    verifyRun("zero", lat, 0, 127, 0, 0);

    $display("[TB] run: single pixel at row 5 col 3, extra start at cycle 100");
    rom[40] = 16'h1000;
    applyStimulus(100, 1'b0, lat);
    verifyRun("single", lat, 1, 5, 5, 1);
    checkOutput("single_px643", int'(ram[643]), 1);
    checkOutput("single_px642", int'(ram[642]), 0);

    $display("[TB] run: 16'hAAAA everywhere after a non-empty image");
    for (int i = 0; i < 1024; i++) rom[i] = 16'hAAAA;
    applyStimulus(0, 1'b1, lat);
    verifyRun("stripes", lat, 8192, 0, 127, 1);
    checkOutput("stripes_px0", int'(ram[0]), 1);
    checkOutput("stripes_px1", int'(ram[1]), 0);
    checkOutput("stripes_px16382", int'(ram[16382]), 1);
    checkOutput("stripes_px16383", int'(ram[16383]), 0);

    $display("[TB] run: rows 10..20 solid, reset at cycle 5000");
    for (int i = 0; i < 1024; i++) rom[i] = (i >= 80 && i < 168) ? 16'hFFFF : 16'h0000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4999);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_res_wr", int'(res_wr), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_sti_rd", int'(sti_rd), 0);
    checkOutput("abort_obj_cnt", int'(obj_cnt), 0);
    checkOutput("abort_row_min", int'(row_min), 127);
    checkOutput("abort_row_max", int'(row_max), 0);
    checkOutput("abort_rows_valid", int'(rows_valid), 0);
    reset = 1'b0;
    snap = wrCnt;
    tick(5);
    checkOutput("abort_no_writes", wrCnt - snap, 0);

    $display("[TB] run: rows 10..20 solid, full reload");
    applyStimulus(0, 1'b0, lat);
    verifyRun("band", lat, 1408, 10, 20, 1);
    checkOutput("band_px1279", int'(ram[1279]), 0);
    checkOutput("band_px1280", int'(ram[1280]), 1);
    checkOutput("band_px2687", int'(ram[2687]), 1);
    checkOutput("band_px2688", int'(ram[2688]), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
